regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 16-entry register file (s0-s7 = 0-7, t0-t7 = 8-15).
- Arbitrates two writeback sources: A = ALU result, B = memory load.
- Keeps a pending-write scoreboard so decode can stall on RAW/WAW hazards.
- Drives the register file's write-enable, write-address and write-data inputs from registered outputs.

Parameters:
- NREGS, 16, number of architected registers; indices >= NREGS are invalid.
- AW, 5, register index width.
- DW, 32, data width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low: state clears on a posedge where reset==0.
- issue_valid  in  1  decode requests allocation of a destination register.
- issue_dst  in  AW  destination index being allocated.
- issue_ready  out  1  allocation accepted this cycle (combinational).
- a_valid  in  1  source A has a result.
- a_dst  in  AW  source A destination.
- a_data  in  DW  source A value.
- a_ready  out  1  source A accepted this cycle (combinational).
- b_valid  in  1  source B has a result.
- b_dst  in  AW  source B destination.
- b_data  in  DW  source B value.
- b_ready  out  1  source B accepted this cycle (combinational).
- rs  in  AW  decode read index A.
- rt  in  AW  decode read index B.
- hazard  out  1  rs or rt has a pending write (combinational).
- rf_wr  out  1  register file write enable (registered).
- rf_controle  out  AW  register file write index (registered).
- rf_entrada  out  DW  register file write data (registered).
- wb_error  out  1  one-cycle pulse: writeback to a non-pending or invalid index (registered).

Behaviour:
- Reset values:
  - rf_wr=0, rf_controle=0, rf_entrada=0, wb_error=0.
  - scoreboard pending[15:0]=0.
  - round-robin pointer last_grant=B, so A wins the first conflict.
  - Any in-flight write is discarded. Reset has priority over every other event.
- Arbitration, one acceptance per cycle:
  - Only a_valid: a_ready=1.
  - Only b_valid: b_ready=1.
  - Both valid: grant the source that is not last_grant; last_grant updates to the winner.
  - The loser holds valid, dst and data stable until accepted.
  - Neither valid: no grant; last_grant unchanged.
  - ready never depends on the other source's data.
- Write pipeline, latency 1:
  - On an accept edge with dst < NREGS: next cycle rf_wr=1, rf_controle=dst, rf_entrada=data.
  - The register file commits on the following edge.
  - With no accept, rf_wr=0 next cycle; rf_controle and rf_entrada hold.
- Invalid writeback index (dst >= NREGS):
  - Accepted and dropped: rf_wr stays 0.
  - wb_error pulses 1 the next cycle.
  - The write port never sees an index >= NREGS.
- Writeback to a valid index whose pending bit is 0:
  - Still written.
  - wb_error pulses next cycle; scoreboard unchanged.
- Scoreboard set:
  - issue_ready = issue_valid & (issue_dst < NREGS) & ~pending[issue_dst].
  - On issue_valid & issue_ready, pending[issue_dst] is set at that edge.
- Scoreboard clear:
  - pending[rf_controle] clears on the edge where rf_wr==1, i.e. the register file commit edge.
  - hazard is therefore guaranteed stale-free: a read is allowed only after the value is in the file.
- Simultaneous set and clear of the same index in one edge:
  - The clear applies first, then the set. Net pending=1.
  - issue_ready evaluates pending before the edge, so this case arises only when the write is committing that edge.
  - For that case only, issue_ready treats pending[idx] as 0 when rf_wr & rf_controle==idx.
- Hazard:
  - hazard = (rs<NREGS & pending[rs]) | (rt<NREGS & pending[rt]).
  - Indices >= NREGS never raise hazard.
- No internal FIFO: back-pressure is only via a_ready/b_ready.
- Worst-case wait for either source under continuous contention is 1 cycle.

Test Plan:
1. Reset then issue dst=3 -> pending[3]=1. A writes dst=3, data=0xDEADBEEF -> next cycle rf_wr=1, rf_controle=3, rf_entrada=0xDEADBEEF. With rs=3: hazard=1 until the commit edge, then 0.
2. A and B valid continuously for 4 cycles (dst 8, 9) -> grants A, B, A, B. Exactly one ready per cycle; rf_wr high 4 consecutive cycles with alternating indices.
3. issue dst=5 twice back-to-back -> second issue_ready=0 (WAW) until dst 5 commits. Issue in the commit cycle -> issue_ready=1 and pending[5] remains 1.
4. B writes dst=20 -> b_ready=1, rf_wr stays 0, wb_error=1 for exactly one cycle. Separately, A writes non-pending dst=7 -> rf_wr=1 and wb_error=1.
5. Pending 2 and 12 set, B accepted, reset=0 on the next edge -> rf_wr=0, pending all 0, hazard=0, wb_error=0. First conflict after reset goes to A.
6. rs=31, rt=15 with pending all 0 -> hazard=0. Issue dst=15 -> hazard=1 next cycle.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Owns the single write port of the register file. Arbitrates two
//   writeback sources (A = ALU, B = load) round-robin, one acceptance per
//   cycle. It registers the winning write onto the rf_* port with a
//   latency of 1. It also keeps a pending-write scoreboard so that decode
//   can stall on RAW/WAW hazards.
// Ports
//   clock, reset          : clock; synchronous active-low reset
//   issue_valid/dst/ready : decode allocates a destination (sets pending)
//   a_*, b_*              : writeback sources, valid/ready handshake
//   rs, rt, hazard        : decode read indices and stall indication
//   rf_wr/controle/entrada: registered register-file write port
//   wb_error              : one-cycle pulse, bad writeback index
module regfile_wb_scheduler #(
    parameter int NREGS = 16,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_dst,
    output logic          issue_ready,
    input  logic          a_valid,
    input  logic [AW-1:0] a_dst,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_dst,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic          hazard,
    output logic          rf_wr,
    output logic [AW-1:0] rf_controle,
    output logic [DW-1:0] rf_entrada,
    output logic          wb_error
);
    localparam int            IW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [AW-1:0] NR = AW'(NREGS);

    logic [NREGS-1:0] pending_q, pending_d;
    logic             last_b_q;       // 1: B won the most recent conflict
    logic             rf_wr_q, rf_wr_d;
    logic [AW-1:0]    rf_idx_q, rf_idx_d;
    logic [DW-1:0]    rf_data_q, rf_data_d;
    logic             err_q, err_d;

    logic          acc, acc_ok, issue_ok, commit_same;
    logic [AW-1:0] acc_dst;
    logic [DW-1:0] acc_data;

    // Round-robin: on a conflict the source that did not win last time
    // gets the grant. Ready depends only on the valids and the pointer.
    assign a_ready  = a_valid & (~b_valid | last_b_q);
    assign b_ready  = b_valid & (~a_valid | ~last_b_q);
    assign acc      = a_ready | b_ready;
    assign acc_dst  = a_ready ? a_dst  : b_dst;
    assign acc_data = a_ready ? a_data : b_data;
    assign acc_ok   = acc_dst < NR;

    // A write committing this edge frees its index, so an issue to that
    // same index can be accepted now (the clear applies before the set).
    assign issue_ok    = issue_dst < NR;
    assign commit_same = rf_wr_q & (rf_idx_q == issue_dst);
    assign issue_ready = issue_valid & issue_ok &
                         (~pending_q[issue_dst[IW-1:0]] | commit_same);

    assign hazard = ((rs < NR) & pending_q[rs[IW-1:0]]) |
                    ((rt < NR) & pending_q[rt[IW-1:0]]);

    always_comb begin
        pending_d = pending_q;
        if (rf_wr_q)
            pending_d[rf_idx_q[IW-1:0]] = 1'b0;
        if (issue_ready)
            pending_d[issue_dst[IW-1:0]] = 1'b1;

        // Invalid indices are accepted but never reach the write port.
        rf_wr_d   = acc & acc_ok;
        rf_idx_d  = rf_wr_d ? acc_dst  : rf_idx_q;
        rf_data_d = rf_wr_d ? acc_data : rf_data_q;
        err_d     = acc & (~acc_ok | ~pending_q[acc_dst[IW-1:0]]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_q <= '0;
            last_b_q  <= 1'b1;
            rf_wr_q   <= 1'b0;
            rf_idx_q  <= '0;
            rf_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            // The pointer only moves when there was a contest to settle.
            if (a_valid & b_valid)
                last_b_q <= b_ready;
            rf_wr_q   <= rf_wr_d;
            rf_idx_q  <= rf_idx_d;
            rf_data_q <= rf_data_d;
            err_q     <= err_d;
        end
    end

    assign rf_wr       = rf_wr_q;
    assign rf_controle = rf_idx_q;
    assign rf_entrada  = rf_data_q;
    assign wb_error    = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_dst = '0;
    logic        issue_ready;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_dst = '0, b_dst = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready;
    logic [4:0]  rs = '0, rt = '0;
    logic        hazard, rf_wr, wb_error;
    logic [4:0]  rf_controle;
    logic [31:0] rf_entrada;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wr;
        logic        err;
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;
    exp_t exq[$];

    regfile_wb_scheduler dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(issue_ready),
        .a_valid(a_valid), .a_dst(a_dst), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_dst(b_dst), .b_data(b_data), .b_ready(b_ready),
        .rs(rs), .rt(rt), .hazard(hazard),
        .rf_wr(rf_wr), .rf_controle(rf_controle), .rf_entrada(rf_entrada),
        .wb_error(wb_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic wr, input logic err, input logic [4:0] idx,
                        input logic [31:0] data);
        exp_t e;
        e.wr = wr; e.err = err; e.idx = idx; e.data = data;
        exq.push_back(e);
    endtask

    task automatic do_reset();
        issue_valid = 0; a_valid = 0; b_valid = 0; rs = 0; rt = 0;
        reset = 0;
        tick(); tick();
        reset = 1;
    endtask

    // Monitor: every write-port event must match the next expectation.
    always @(negedge clock) begin
        if (rf_wr || wb_error) begin
            if (exq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_wb: rf_wr=%0b idx=%0d data=%h err=%0b",
                         rf_wr, rf_controle, rf_entrada, wb_error);
            end else begin
                exp_t e;
                e = exq.pop_front();
                chk("mon_rf_wr", 32'(rf_wr), 32'(e.wr));
                chk("mon_wb_error", 32'(wb_error), 32'(e.err));
                if (e.wr) begin
                    chk("mon_rf_controle", 32'(rf_controle), 32'(e.idx));
                    chk("mon_rf_entrada", rf_entrada, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- reset state
        do_reset();
        settle();
        chk("rst_rf_wr", 32'(rf_wr), 0);
        chk("rst_rf_controle", 32'(rf_controle), 0);
        chk("rst_rf_entrada", rf_entrada, 0);
        chk("rst_wb_error", 32'(wb_error), 0);
        chk("rst_hazard", 32'(hazard), 0);

        // ---- 1: issue 3, write 3, hazard clears on commit edge
        issue_valid = 1; issue_dst = 3;
        settle(); chk("t1_issue_ready", 32'(issue_ready), 1);
        tick();
        issue_valid = 0; rs = 3;
        settle(); chk("t1_hazard_pend", 32'(hazard), 1);
        a_valid = 1; a_dst = 3; a_data = 32'hDEADBEEF;
        push(1, 0, 3, 32'hDEADBEEF);
        settle(); chk("t1_a_ready", 32'(a_ready), 1);
        tick();
        a_valid = 0;
        settle(); chk("t1_hazard_wr", 32'(hazard), 1);
        tick();
        settle(); chk("t1_hazard_commit", 32'(hazard), 0);
        rs = 0;

        // ---- 2: continuous contention A(8)/B(9) -> A,B,A,B
        do_reset();
        issue_valid = 1; issue_dst = 8; tick();
        issue_dst = 9; tick();
        issue_valid = 0;
        a_valid = 1; a_dst = 8; a_data = 32'hA0;
        b_valid = 1; b_dst = 9; b_data = 32'hB0;
        settle(); chk("t2_c0_a", 32'(a_ready), 1); chk("t2_c0_b", 32'(b_ready), 0);
        push(1, 0, 8, 32'hA0);
        tick();
        a_data = 32'hA1;
        settle(); chk("t2_c1_a", 32'(a_ready), 0); chk("t2_c1_b", 32'(b_ready), 1);
        push(1, 0, 9, 32'hB0);
        tick();
        b_data = 32'hB1;
        settle(); chk("t2_c2_a", 32'(a_ready), 1); chk("t2_c2_b", 32'(b_ready), 0);
        push(1, 1, 8, 32'hA1);   // pending[8] already cleared by first commit
        tick();
        settle(); chk("t2_c3_a", 32'(a_ready), 0); chk("t2_c3_b", 32'(b_ready), 1);
        push(1, 1, 9, 32'hB1);
        tick();
        a_valid = 0; b_valid = 0;
        tick(); tick();

        // ---- 3: WAW stall on 5, issue in commit cycle
        issue_valid = 1; issue_dst = 5;
        settle(); chk("t3_first_issue", 32'(issue_ready), 1);
        tick();
        a_valid = 1; a_dst = 5; a_data = 32'h55;
        push(1, 0, 5, 32'h55);
        settle(); chk("t3_waw_stall", 32'(issue_ready), 0);
        tick();
        a_valid = 0;
        settle(); chk("t3_commit_issue", 32'(issue_ready), 1);
        tick();
        issue_valid = 0; rs = 5;
        settle(); chk("t3_still_pending", 32'(hazard), 1);
        issue_valid = 1;
        settle(); chk("t3_reissue_block", 32'(issue_ready), 0);
        issue_valid = 0;
        a_valid = 1; a_data = 32'h66;
        push(1, 0, 5, 32'h66);
        tick();
        a_valid = 0;
        tick(); tick();
        settle(); chk("t3_cleared", 32'(hazard), 0);
        rs = 0;

        // ---- 4: invalid index and non-pending writeback
        b_valid = 1; b_dst = 20; b_data = 32'h1234;
        push(0, 1, 0, 0);
        settle(); chk("t4_b_ready", 32'(b_ready), 1);
        tick();
        b_valid = 0;
        settle(); chk("t4_no_write", 32'(rf_wr), 0); chk("t4_err_pulse", 32'(wb_error), 1);
        tick();
        settle(); chk("t4_err_one_cycle", 32'(wb_error), 0);
        a_valid = 1; a_dst = 7; a_data = 32'h77;
        push(1, 1, 7, 32'h77);
        tick();
        a_valid = 0;
        tick();

        // ---- 5: reset while B accepted discards it
        issue_valid = 1; issue_dst = 2; tick();
        issue_dst = 12; tick();
        issue_valid = 0; rs = 2; rt = 12;
        settle(); chk("t5_hazard_pre", 32'(hazard), 1);
        b_valid = 1; b_dst = 2; b_data = 32'h22;
        reset = 0;
        tick();
        reset = 1; b_valid = 0;
        settle();
        chk("t5_rf_wr", 32'(rf_wr), 0);
        chk("t5_wb_error", 32'(wb_error), 0);
        chk("t5_hazard", 32'(hazard), 0);
        a_valid = 1; a_dst = 10; a_data = 32'hAA;
        b_valid = 1; b_dst = 11; b_data = 32'hBB;
        settle(); chk("t5_conf_a", 32'(a_ready), 1); chk("t5_conf_b", 32'(b_ready), 0);
        push(1, 1, 10, 32'hAA);
        tick();
        a_valid = 0;
        settle(); chk("t5_b_alone", 32'(b_ready), 1);
        push(1, 1, 11, 32'hBB);
        tick();
        b_valid = 0; rs = 0; rt = 0;
        tick();

        // ---- 6: out-of-range read index, boundary issue index
        rs = 31; rt = 15;
        settle(); chk("t6_hazard_none", 32'(hazard), 0);
        issue_valid = 1; issue_dst = 20;
        settle(); chk("t6_issue_invalid", 32'(issue_ready), 0);
        issue_dst = 15;
        settle(); chk("t6_issue_15", 32'(issue_ready), 1);
        tick();
        issue_valid = 0;
        settle(); chk("t6_hazard_15", 32'(hazard), 1);

        tick(); tick(); tick();
        n_cmp++;
        if (exq.size() != 0) begin
            n_bad++;
            $display("FAIL missing_wb: %0d expected events never seen, required 0", exq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
